// File: rtl/unsigned_max_stream.sv
// Streaming block max/argmax: a pairwise {value, lane} compare tree per beat,
// followed by an accumulator that folds `beats` tree results into one block result.
module unsigned_max_stream #(
  parameter int unsigned width     = 8,
  parameter int unsigned lanes     = 8,
  parameter int unsigned beats     = 4,
  parameter int unsigned pl_freq   = 1,
  parameter int unsigned is_signed = 0,
  localparam int unsigned IW = ($clog2(lanes * beats) < 1) ? 1 : $clog2(lanes * beats)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  input  logic [lanes-1:0][width-1:0]   i_data,
  output logic                          o_valid,
  output logic [width-1:0]              o_max,
  output logic [IW-1:0]                 o_idx
);

  localparam int unsigned D  = $clog2(lanes);
  localparam int unsigned LW = D;
  localparam int unsigned BW = (beats > 1) ? $clog2(beats) : 1;

  function automatic logic ge(input logic [width-1:0] a, input logic [width-1:0] b);
    if (is_signed != 0) return $signed(a) >= $signed(b);
    return a >= b;
  endfunction

  function automatic logic gt(input logic [width-1:0] a, input logic [width-1:0] b);
    if (is_signed != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // One compare layer per level; the layer input is optionally registered.
  for (genvar i = 0; i < D; i++) begin : g_lvl
    localparam int unsigned NI = lanes >> i;
    localparam int unsigned NO = NI / 2;

    logic [NI-1:0][width-1:0] in_val;
    logic [NI-1:0][LW-1:0]    in_idx;
    logic                     in_vld;
    logic [NO-1:0][width-1:0] out_val;
    logic [NO-1:0][LW-1:0]    out_idx;
    logic                     out_vld;

    if (i == 0) begin : g_src
      always_comb begin
        in_val = i_data;
        in_vld = i_valid;
        for (int k = 0; k < int'(NI); k++) in_idx[k] = LW'(k);
      end
    end else if ((i % pl_freq) == 0) begin : g_reg
      // Payload only loads on valid; the valid flag always follows.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          in_vld <= 1'b0;
          in_val <= '0;
          in_idx <= '0;
        end else begin
          in_vld <= g_lvl[i-1].out_vld;
          if (g_lvl[i-1].out_vld) begin
            in_val <= g_lvl[i-1].out_val;
            in_idx <= g_lvl[i-1].out_idx;
          end
        end
      end
    end else begin : g_wire
      assign in_vld = g_lvl[i-1].out_vld;
      assign in_val = g_lvl[i-1].out_val;
      assign in_idx = g_lvl[i-1].out_idx;
    end

    // Lower-index operand wins ties.
    always_comb begin
      out_vld = in_vld;
      for (int k = 0; k < int'(NO); k++) begin
        if (ge(in_val[2*k], in_val[2*k+1])) begin
          out_val[k] = in_val[2*k];
          out_idx[k] = in_idx[2*k];
        end else begin
          out_val[k] = in_val[2*k+1];
          out_idx[k] = in_idx[2*k+1];
        end
      end
    end
  end

  logic             tv;
  logic [width-1:0] tval;
  logic [LW-1:0]    tlane;

  assign tv    = g_lvl[D-1].out_vld;
  assign tval  = g_lvl[D-1].out_val[0];
  assign tlane = g_lvl[D-1].out_idx[0];

  logic [BW-1:0]    bc, bc_nxt;
  logic [width-1:0] acc, acc_nxt;
  logic [IW-1:0]    acc_idx, acc_idx_nxt;
  logic [IW-1:0]    t_pos_c;
  logic             emit_c;

  // Beat counter doubles as the IDLE/ACCUM/EMIT state; earlier beat wins ties.
  always_comb begin
    bc_nxt      = bc;
    acc_nxt     = acc;
    acc_idx_nxt = acc_idx;
    emit_c      = 1'b0;
    t_pos_c     = IW'(IW'(bc) * IW'(lanes)) + IW'(tlane);
    if (tv) begin
      if ((bc == '0) || gt(tval, acc)) begin
        acc_nxt     = tval;
        acc_idx_nxt = t_pos_c;
      end
      if (bc == BW'(beats - 1)) begin
        bc_nxt = '0;
        emit_c = 1'b1;
      end else begin
        bc_nxt = bc + BW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bc      <= '0;
      acc     <= '0;
      acc_idx <= '0;
      o_valid <= 1'b0;
      o_max   <= '0;
      o_idx   <= '0;
    end else begin
      bc      <= bc_nxt;
      acc     <= acc_nxt;
      acc_idx <= acc_idx_nxt;
      o_valid <= emit_c;
      if (emit_c) begin
        o_max <= acc_nxt;
        o_idx <= acc_idx_nxt;
      end
    end
  end

endmodule

// File: tb/tb_unsigned_max_stream.sv
// Bench for unsigned_max_stream: default unsigned, default signed, and a
// lanes=2/beats=1/pl_freq=4 instance, all checked against a block-level model.
module tb_unsigned_max_stream;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_valid;
  logic [7:0][7:0] d;

  always #5 i_clk = ~i_clk;

  logic       ov_a, ov_s, ov_b;
  logic [7:0] om_a, om_s, om_b;
  logic [4:0] oi_a, oi_s;
  logic [0:0] oi_b;

  unsigned_max_stream #(.width(8), .lanes(8), .beats(4), .pl_freq(1), .is_signed(0)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(d),
    .o_valid(ov_a), .o_max(om_a), .o_idx(oi_a));

  unsigned_max_stream #(.width(8), .lanes(8), .beats(4), .pl_freq(1), .is_signed(1)) dut_s (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(d),
    .o_valid(ov_s), .o_max(om_s), .o_idx(oi_s));

  unsigned_max_stream #(.width(8), .lanes(2), .beats(1), .pl_freq(4), .is_signed(0)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(d[1:0]),
    .o_valid(ov_b), .o_max(om_b), .o_idx(oi_b));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic int nel(int k); return (k == 2) ? 2 : 32; endfunction
  function automatic int nln(int k); return (k == 2) ? 2 : 8;  endfunction
  function automatic int lat(int k); return (k == 2) ? 0 : 2;  endfunction

  function automatic bit gtr(int k, logic [7:0] a, logic [7:0] b);
    if (k == 1) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  typedef struct {int k; int due; int mx; int idx;} exp_t;
  exp_t q[$];

  int ecnt = 0;
  int cnt[3];
  logic [7:0] blk[3][32];
  int mlast_max[3], mlast_idx[3];

  // Model: gather whole blocks, scan for first strict maximum, schedule result.
  always @(posedge i_clk) begin
    ecnt++;
    if (i_rst) begin
      for (int k = 0; k < 3; k++) cnt[k] = 0;
      q.delete();
    end else if (i_valid) begin
      for (int k = 0; k < 3; k++) begin
        for (int l = 0; l < nln(k); l++) blk[k][cnt[k] + l] = d[l];
        cnt[k] += nln(k);
        if (cnt[k] == nel(k)) begin
          int mi;
          logic [7:0] mv;
          exp_t e;
          mv = blk[k][0];
          mi = 0;
          for (int j = 1; j < nel(k); j++)
            if (gtr(k, blk[k][j], mv)) begin mv = blk[k][j]; mi = j; end
          e.k = k; e.due = ecnt + lat(k); e.mx = int'(mv); e.idx = mi;
          q.push_back(e);
          mlast_max[k] = int'(mv);
          mlast_idx[k] = mi;
          cnt[k] = 0;
        end
      end
    end
  end

  int hmax[3], hidx[3], pcnt[3];
  int lmax[3], lidx[3], ledge[3], pmax[3], pidx[3], pedge[3];

  // Every cycle out of reset: pulse timing, value and held outputs.
  always @(negedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 3; k++) begin hmax[k] = 0; hidx[k] = 0; end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int av, am, ai, hit;
        case (k)
          0: begin av = int'(ov_a); am = int'(om_a); ai = int'(oi_a); end
          1: begin av = int'(ov_s); am = int'(om_s); ai = int'(oi_s); end
          default: begin av = int'(ov_b); am = int'(om_b); ai = int'(oi_b); end
        endcase
        hit = -1;
        for (int j = 0; j < q.size(); j++)
          if (q[j].k == k && q[j].due == ecnt) hit = j;
        if (hit >= 0) begin
          hmax[k] = q[hit].mx;
          hidx[k] = q[hit].idx;
          q.delete(hit);
        end
        chk($sformatf("o_valid[inst%0d]", k), av, (hit >= 0) ? 1 : 0);
        chk($sformatf("o_max[inst%0d]", k), am, hmax[k]);
        chk($sformatf("o_idx[inst%0d]", k), ai, hidx[k]);
        if (av == 1) begin
          pcnt[k]++;
          pmax[k] = lmax[k]; pidx[k] = lidx[k]; pedge[k] = ledge[k];
          lmax[k] = am; lidx[k] = ai; ledge[k] = ecnt;
        end
      end
    end
  end

  int lbe;
  logic [7:0] el[32];
  logic [7:0] el2[32];

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic send_beat(input logic [7:0] e[32], input int b);
    for (int l = 0; l < 8; l++) d[l] = e[b*8 + l];
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    lbe = ecnt;
    i_valid = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] e[32], input int gap);
    for (int b = 0; b < 4; b++) begin
      send_beat(e, b);
      if (gap > 0 && b < 3) idle(gap);
    end
  endtask

  initial begin
    int p0;
    i_rst = 1'b1; i_valid = 1'b0; d = '0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    idle(2);
    chk("reset_valid_a", int'(ov_a), 0);
    chk("reset_max_a", int'(om_a), 0);
    chk("reset_idx_a", int'(oi_a), 0);
    chk("reset_max_b", int'(om_b), 0);

    // Ascending 0..31.
    for (int j = 0; j < 32; j++) el[j] = 8'(j);
    p0 = pcnt[0];
    send_block(el, 0); idle(6);
    chk("asc_model_max", mlast_max[0], 31);
    chk("asc_max_a", lmax[0], 31);
    chk("asc_idx_a", lidx[0], 31);
    chk("asc_latency_a", ledge[0] - lbe, 2);
    chk("asc_pulses_a", pcnt[0] - p0, 1);
    chk("asc_max_s", lmax[1], 31);
    chk("asc_max_b", lmax[2], 25);
    chk("asc_idx_b", lidx[2], 1);
    chk("asc_latency_b", ledge[2] - lbe, 0);

    // All equal: lowest index wins.
    for (int j = 0; j < 32; j++) el[j] = 8'h55;
    send_block(el, 0); idle(6);
    chk("tie_max_a", lmax[0], 8'h55);
    chk("tie_idx_a", lidx[0], 0);
    chk("tie_idx_b", lidx[2], 0);

    // Single peak at beat 2 lane 5 with idle gaps.
    for (int j = 0; j < 32; j++) el[j] = 8'h10;
    el[21] = 8'hF0;
    p0 = pcnt[0];
    send_block(el, 2); idle(6);
    chk("gap_model_idx", mlast_idx[0], 21);
    chk("gap_max_a", lmax[0], 8'hF0);
    chk("gap_idx_a", lidx[0], 21);
    chk("gap_latency_a", ledge[0] - lbe, 2);
    chk("gap_pulses_a", pcnt[0] - p0, 1);
    chk("gap_max_s", lmax[1], 8'h10);
    chk("gap_idx_s", lidx[1], 0);

    // Back-to-back blocks.
    for (int j = 0; j < 32; j++) begin el[j] = 8'h01; el2[j] = 8'h01; end
    el[11] = 8'h7F;
    el2[31] = 8'h03;
    send_block(el, 0);
    send_block(el2, 0);
    idle(6);
    chk("b2b_first_max_a", pmax[0], 8'h7F);
    chk("b2b_first_idx_a", pidx[0], 11);
    chk("b2b_second_max_a", lmax[0], 8'h03);
    chk("b2b_second_idx_a", lidx[0], 31);
    chk("b2b_spacing_a", ledge[0] - pedge[0], 4);

    // Signed vs unsigned compare.
    for (int j = 0; j < 32; j++) el[j] = 8'h00;
    el[2] = 8'h80;
    el[30] = 8'h7F;
    send_block(el, 0); idle(6);
    chk("sgn_model_max_s", mlast_max[1], 8'h7F);
    chk("sgn_max_unsigned", lmax[0], 8'h80);
    chk("sgn_idx_unsigned", lidx[0], 2);
    chk("sgn_max_signed", lmax[1], 8'h7F);
    chk("sgn_idx_signed", lidx[1], 30);

    // Reset discards a partial block.
    for (int j = 0; j < 32; j++) el[j] = 8'h09;
    p0 = pcnt[0];
    send_beat(el, 0);
    send_beat(el, 1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    for (int j = 0; j < 32; j++) el[j] = 8'h01;
    send_block(el, 0); idle(6);
    chk("rst_pulses_a", pcnt[0] - p0, 1);
    chk("rst_max_a", lmax[0], 8'h01);
    chk("rst_idx_a", lidx[0], 0);

    chk("pending_results", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
